// File: rtl/sram_prog_loader.sv
// sram_prog_loader: packs a host byte stream little-endian into 16-bit words
// and writes them to an asynchronous SRAM. Each word gets a fixed cycle
// sequence: SETUP (1), WRITE (WE_CYCLES with we_n low), HOLD (1). Word
// addresses advance from BASE_ADDR. If the top of the address space is
// written and more data follows, the loader parks in FULL until reset.
//
// Optional feature: define SRAM_WRITE_VERIFY_EN to read each word back
// (RD1, RD2) after HOLD. The enabled byte lanes are compared, and the first
// mismatching address is latched.
module sram_prog_loader #(
  parameter int          WE_CYCLES = 2,
  parameter logic [19:0] BASE_ADDR = 20'h00000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  output logic        in_ready,
  output logic [19:0] sram_addr,
  output logic [15:0] sram_dq_out,
  output logic        sram_dq_oe,
  input  logic [15:0] sram_dq_in,
  output logic        sram_ce_n,
  output logic        sram_we_n,
  output logic        sram_oe_n,
  output logic        sram_lb_n,
  output logic        sram_ub_n,
  output logic        busy,
  output logic        done,
  output logic [20:0] word_count,
  output logic        overflow,
  output logic        verify_err,
  output logic [19:0] err_addr
);

  typedef enum logic [2:0] {
    S_COLLECT_LO,
    S_COLLECT_HI,
    S_SETUP,
    S_WRITE,
    S_HOLD,
    S_RD1,
    S_RD2,
    S_FULL
  } state_t;

  // Terminal value of the we_n-low cycle counter.
  localparam logic [3:0] WE_LAST = 4'(WE_CYCLES - 1);

  state_t      state_reg;
  logic [7:0]  lo_byte_reg;
  logic        last_reg;
  logic [3:0]  we_cnt_reg;
  logic [19:0] addr_reg;
  logic [15:0] dq_out_reg;
  logic        dq_oe_reg;
  logic        ce_n_reg;
  logic        we_n_reg;
  logic        oe_n_reg;
  logic        lb_n_reg;
  logic        ub_n_reg;
  logic        busy_reg;
  logic        done_reg;
  logic [20:0] word_count_reg;
  logic        overflow_reg;
  logic        word_end;

  // The SRAM cycle for one word is finished in the last state of its
  // sequence. That is HOLD, or RD2 when readback is built in.
`ifdef SRAM_WRITE_VERIFY_EN
  assign word_end = (state_reg == S_RD2);
`else
  assign word_end = (state_reg == S_HOLD);
`endif

  assign in_ready    = (state_reg == S_COLLECT_LO) || (state_reg == S_COLLECT_HI);
  assign sram_addr   = addr_reg;
  assign sram_dq_out = dq_out_reg;
  assign sram_dq_oe  = dq_oe_reg;
  assign sram_ce_n   = ce_n_reg;
  assign sram_we_n   = we_n_reg;
  assign sram_oe_n   = oe_n_reg;
  assign sram_lb_n   = lb_n_reg;
  assign sram_ub_n   = ub_n_reg;
  assign busy        = busy_reg;
  assign done        = done_reg;
  assign word_count  = word_count_reg;
  assign overflow    = overflow_reg;

  // Main FSM. It collects bytes, sequences the SRAM write cycle, and
  // advances the address.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= S_COLLECT_LO;
      lo_byte_reg    <= 8'h00;
      last_reg       <= 1'b0;
      we_cnt_reg     <= 4'd0;
      addr_reg       <= BASE_ADDR;
      dq_out_reg     <= 16'h0000;
      dq_oe_reg      <= 1'b0;
      ce_n_reg       <= 1'b1;
      we_n_reg       <= 1'b1;
      oe_n_reg       <= 1'b1;
      lb_n_reg       <= 1'b1;
      ub_n_reg       <= 1'b1;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      word_count_reg <= 21'd0;
      overflow_reg   <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        S_COLLECT_LO: begin
          if (in_valid) begin
            lo_byte_reg <= in_data;
            // The first byte of a new image restarts the word count.
            if (!busy_reg) begin
              word_count_reg <= 21'd0;
              busy_reg       <= 1'b1;
            end
            if (in_last) begin
              // An odd-length image ends with a low-lane-only write.
              dq_out_reg <= {8'h00, in_data};
              lb_n_reg   <= 1'b0;
              ub_n_reg   <= 1'b1;
              ce_n_reg   <= 1'b0;
              dq_oe_reg  <= 1'b1;
              last_reg   <= 1'b1;
              state_reg  <= S_SETUP;
            end else begin
              state_reg <= S_COLLECT_HI;
            end
          end
        end
        S_COLLECT_HI: begin
          if (in_valid) begin
            dq_out_reg <= {in_data, lo_byte_reg};
            lb_n_reg   <= 1'b0;
            ub_n_reg   <= 1'b0;
            ce_n_reg   <= 1'b0;
            dq_oe_reg  <= 1'b1;
            last_reg   <= in_last;
            state_reg  <= S_SETUP;
          end
        end
        S_SETUP: begin
          // Address and data have been stable for one full cycle here.
          we_n_reg   <= 1'b0;
          we_cnt_reg <= 4'd0;
          state_reg  <= S_WRITE;
        end
        S_WRITE: begin
          if (we_cnt_reg == WE_LAST) begin
            we_n_reg  <= 1'b1;
            state_reg <= S_HOLD;
          end else begin
            we_cnt_reg <= we_cnt_reg + 4'd1;
          end
        end
        S_HOLD: begin
`ifdef SRAM_WRITE_VERIFY_EN
          // Turn the bus around: release DQ and enable the SRAM outputs.
          dq_oe_reg <= 1'b0;
          oe_n_reg  <= 1'b0;
          state_reg <= S_RD1;
`endif
        end
        S_RD1: begin
          state_reg <= S_RD2;
        end
        S_RD2: begin
          // Word completion is handled by the word_end block below.
        end
        S_FULL: begin
          // Parked until reset. No further SRAM cycles are started.
        end
        default: begin
          state_reg <= S_COLLECT_LO;
        end
      endcase

      if (word_end) begin
        ce_n_reg       <= 1'b1;
        oe_n_reg       <= 1'b1;
        lb_n_reg       <= 1'b1;
        ub_n_reg       <= 1'b1;
        dq_oe_reg      <= 1'b0;
        word_count_reg <= word_count_reg + 21'd1;
        if (last_reg) begin
          done_reg  <= 1'b1;
          busy_reg  <= 1'b0;
          addr_reg  <= BASE_ADDR;
          last_reg  <= 1'b0;
          state_reg <= S_COLLECT_LO;
        end else if (addr_reg == 20'hFFFFF) begin
          overflow_reg <= 1'b1;
          state_reg    <= S_FULL;
        end else begin
          addr_reg  <= addr_reg + 20'd1;
          state_reg <= S_COLLECT_LO;
        end
      end
    end
  end

`ifdef SRAM_WRITE_VERIFY_EN
  logic        verify_err_reg;
  logic [19:0] err_addr_reg;
  logic        lane_mismatch;

  // Only the byte lanes that were written take part in the comparison.
  assign lane_mismatch = (!lb_n_reg && (sram_dq_in[7:0]  != dq_out_reg[7:0])) ||
                         (!ub_n_reg && (sram_dq_in[15:8] != dq_out_reg[15:8]));

  assign verify_err = verify_err_reg;
  assign err_addr   = err_addr_reg;

  // Readback check at the end of RD2. The error flag is sticky, and only
  // the first failing address is kept.
  always_ff @(posedge clk) begin
    if (reset) begin
      verify_err_reg <= 1'b0;
      err_addr_reg   <= 20'h00000;
    end else if ((state_reg == S_RD2) && lane_mismatch) begin
      verify_err_reg <= 1'b1;
      if (!verify_err_reg) begin
        err_addr_reg <= addr_reg;
      end
    end
  end
`else
  logic unused_dq_in;

  assign unused_dq_in = ^sram_dq_in;
  assign verify_err   = 1'b0;
  assign err_addr     = 20'h00000;
`endif

endmodule
